// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM/WB operand forwarding and load-use bubble insertion
module id_ex_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_dst,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [15:0] in_ctrl,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] ex_result,
  input  logic        mem_wen,
  input  logic        wb_wen,
  input  logic [4:0]  mem_dst,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] mem_data,
  input  logic [31:0] wb_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_dst,
  output logic        out_wen,
  output logic        out_is_load,
  output logic [15:0] out_ctrl,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic [15:0] bubble_cnt
);
  logic        ex_ok, mem_ok, wb_ok, hazard;
  logic [31:0] fwd_a, fwd_b;
  assign ra1 = in_rs;
  assign ra2 = in_rt;
  // a load in EX has no result yet; it is covered by the bubble instead
  assign ex_ok  = out_valid & out_wen & ~out_is_load & (out_dst != 5'd0);
  assign mem_ok = mem_wen & (mem_dst != 5'd0);
  assign wb_ok  = wb_wen & (wb_dst != 5'd0);
  always_comb begin
    fwd_a = ex_ok && out_dst == in_rs ? ex_result :
            mem_ok && mem_dst == in_rs ? mem_data :
            wb_ok && wb_dst == in_rs ? wb_data : rd1;
    fwd_b = ex_ok && out_dst == in_rt ? ex_result :
            mem_ok && mem_dst == in_rt ? mem_data :
            wb_ok && wb_dst == in_rt ? wb_data : rd2;
  end
  assign hazard = in_valid & out_valid & out_is_load & out_wen & (out_dst != 5'd0) &
                  ((out_dst == in_rs) | (out_dst == in_rt));
  assign in_ready = ~ex_stall & ~hazard;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_dst     <= '0;
      out_wen     <= 1'b0;
      out_is_load <= 1'b0;
      out_ctrl    <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!ex_stall) begin
      if (hazard) begin
        out_valid <= 1'b0;
        if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
      end else begin
        out_valid   <= in_valid;
        out_a       <= fwd_a;
        out_b       <= fwd_b;
        out_dst     <= in_dst;
        out_wen     <= in_wen;
        out_is_load <= in_is_load;
        out_ctrl    <= in_ctrl;
        out_imm     <= in_imm;
        out_pc      <= in_pc;
      end
    end
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary stage of the pipelined core. It drives the register file read addresses from the decoded instruction and resolves RAW hazards on the returned operands by forwarding from EX, MEM and WB. It also detects load-use hazards, inserting a single bubble for each one. It holds the ID/EX pipeline register consumed by the ALU stage and counts the bubbles it inserts.

## Interface
Parameters:
- none (data path fixed at 32 bits, register index at 5 bits)

Ports:
- clk  in  1  single clock; all state updates on posedge
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs, in_rt  in  5  source register indices
- in_dst  in  5  destination index
- in_wen  in  1  instruction writes in_dst
- in_is_load  in  1  instruction is a load
- in_ctrl  in  16  opaque ALU/memory control, passed through
- in_imm, in_pc  in  32  immediate and PC, passed through
- ra1, ra2  out  5  register file read addresses; combinational copies of in_rs, in_rt
- rd1, rd2  in  32  register file read data; index 0 returns 0
- ex_result  in  32  combinational ALU result of the instruction currently in out_*
- mem_wen, wb_wen  in  1  MEM and WB stage write enables
- mem_dst, wb_dst  in  5  MEM and WB stage destinations
- mem_data, wb_data  in  32  MEM and WB result values (mem_data is final, including load data)
- ex_stall  in  1  downstream stall; hold the register
- flush  in  1  squash the register contents
- out_valid  out  1  ID/EX register valid
- out_a, out_b  out  32  resolved operands
- out_dst, out_wen, out_is_load, out_ctrl, out_imm, out_pc  out  *  registered copies
- bubble_cnt  out  16  saturating count of load-use bubbles

## Operation
- Per-operand forward select, evaluated for rs→a and rt→b in priority order (first match wins):
  - EX: out_valid & out_wen & !out_is_load & out_dst!=0 & out_dst==src → ex_result.
  - MEM: mem_wen & mem_dst!=0 & mem_dst==src → mem_data.
  - WB: wb_wen & wb_dst!=0 & wb_dst==src → wb_data. This covers the regfile write-then-read at the same edge.
  - Otherwise rd1/rd2.
- Index 0 never forwards. Its operand is rd1/rd2, which is 0.
- hazard = in_valid & out_valid & out_is_load & out_wen & out_dst!=0 & (out_dst==in_rs | out_dst==in_rt).
  - The check is conservative: rs and rt are always compared, whether or not the instruction uses them.
- in_ready = !ex_stall & !hazard. in_ready does not depend on flush.
- Register update at posedge, highest priority first:
  1. flush: out_valid←0; the presented instruction is dropped.
  2. ex_stall: hold all out_*.
  3. hazard: out_valid←0 (bubble); other out_* hold; bubble_cnt += 1.
  4. Otherwise: out_valid←in_valid; capture the forwarded operands and all pass-through fields.
- bubble_cnt saturates at 0xFFFF. It increments only in case 3.
- After a bubble, the load is no longer in EX, so hazard deasserts. The load is now in MEM and reaches the dependent instruction through mem_data.

## Timing
- Reset (resetn low, asynchronous): out_valid=0, out_a=out_b=0, out_dst=0, out_wen=0, out_is_load=0, out_ctrl=0, out_imm=0, out_pc=0, bubble_cnt=0.
- in_ready and ra1/ra2 are combinational.
- Latency is one cycle from acceptance to out_*.
- Load-use costs exactly one bubble cycle, then the instruction is accepted.
- Reset deassertion mid-stream: the first posedge after deassertion behaves as a normal update from the reset state. There is no hazard, since out_valid=0.
- flush together with ex_stall or hazard: flush wins, and bubble_cnt does not increment.

## Test plan
- No-hazard pass-through: rs=3, rt=4, regfile returns 0x11/0x22, no forwards → next cycle out_a=0x11, out_b=0x22, out_valid=1.
- Forward priority: rs=5 with EX (ALU, ex_result=0xA), MEM (mem_data=0xB) and WB (wb_data=0xC) all targeting r5 → out_a=0xA. Remove EX → 0xB. Remove MEM → 0xC.
- Load-use: a load to r7 in EX, next instruction rs=7 → one cycle with in_ready=0, out_valid=0 and bubble_cnt=1. The following cycle, with mem_data=0x55, captures out_a=0x55.
- Register zero: out_dst=0 load in EX and rs=0 → no stall, out_a=0, no forward.
- Stall/flush: ex_stall=1 for 3 cycles → out_* held and in_ready=0. flush together with a hazard → out_valid=0 and bubble_cnt unchanged.
- Saturation and reset: force 0x10000 bubbles → bubble_cnt=0xFFFF. Pulse resetn low mid-cycle → all outputs 0 immediately.
